uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, 115200, line bit rate; BIT = CLK_FREQ/BAUD (integer truncation, 868 at defaults); HALF = BIT/2 (434).
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port rx  input  1  asynchronous serial line; idle high; 8N1 framing, LSB first.
REQ-006 Port rx_data  output  8  received byte at head of storage; valid only while rx_valid is high.
REQ-007 Port rx_valid  output  1  storage non-empty.
REQ-008 Port rx_ready  input  1  consumer accepts head byte on any cycle where rx_valid and rx_ready are both high.
REQ-009 Port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 Port overrun  output  1  one-cycle pulse: completed byte dropped because storage full.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; the edge detector uses the synchronized value and its one-cycle-delayed copy.
REQ-012 States: IDLE, START, DATA, STOP, WAIT_HIGH; illegal encodings SHALL return to IDLE.
REQ-013 IDLE: synchronized falling edge (delayed=1, current=0) -> START, cycle of detection = cycle 0, counter loaded.
REQ-014 START: sample at cycle HALF; low -> DATA; high -> glitch, IDLE, no output.
REQ-015 DATA: bit i (i=0..7) sampled at cycle HALF+(i+1)*BIT, shifted in LSB first; after bit 7 -> STOP.
REQ-016 STOP: sample at cycle HALF+9*BIT; high -> byte pushed to storage, IDLE; low -> frame_err pulse next cycle, byte discarded, WAIT_HIGH.
REQ-017 WAIT_HIGH: remain until synchronized rx high, then IDLE; no new frame SHALL start during a held-low (break) line.
REQ-018 Pushed byte SHALL be visible (rx_valid=1, rx_data correct) at cycle HALF+9*BIT+1; total pin-to-valid latency = that + 2 synchronizer cycles.
REQ-019 Pop on rx_valid&&rx_ready; rx_data SHALL hold stable while rx_valid=1 and rx_ready=0.
REQ-020 Push into full storage SHALL drop the new byte, keep stored bytes intact and pulse overrun for one cycle.
REQ-021 Simultaneous pop and push on full storage SHALL succeed with no overrun; on empty storage the pushed byte SHALL appear next cycle (no bypass).
REQ-022 The receiver SHALL never depend on rx_ready to advance its state machine.

Reset
REQ-023 rst high SHALL force: state IDLE, synchronizer flops 1, delayed-rx flop 0, counters 0, shift register 0, storage empty.
REQ-024 Outputs during and after reset: rx_valid=0, rx_data=0x00, frame_err=0, overrun=0.
REQ-025 Reset mid-frame SHALL abandon the frame; delayed-rx=0 ensures no start is detected until rx has been seen high after release.

Configuration
REQ-026 Macro UART_RX_FIFO_EN defined: storage is a 4-entry FIFO, first-in first-out, full at 4, pointers wrap modulo 4.
REQ-027 UART_RX_FIFO_EN undefined: storage is a single holding register, full when rx_valid=1; all other behaviour identical.

Verification
REQ-028 Defaults, send 0x55 8N1 at 115200 -> rx_valid rises 2+434+9*868+1 cycles after rx falls, rx_data=0x55, no error pulses.
REQ-029 rx low for 100 clocks then high -> no rx_valid, no frame_err; following byte 0xA3 received correctly.
REQ-030 Byte 0x3C with stop bit low, line held low 20 bit-times then high -> one frame_err pulse, no rx_valid; then 0xA3 received correctly.
REQ-031 FIFO undefined, rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, one overrun pulse; with FIFO defined send 0x01..0x05 -> 0x01..0x04 popped in order, one overrun for 0x05.
REQ-032 Full storage, rx_ready=1 on the push cycle -> no overrun, new byte retained behind existing bytes.
REQ-033 rst asserted mid-DATA of 0xFF, released with rx low -> no byte until rx high; next 0x5A received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a two-flop input synchronizer, a mid-bit
// sampling state machine and a small output store.
// Build option: define UART_RX_FIFO_EN for a 4-entry FIFO store; without it
// the store is a single holding register.
module uart_rx #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int BIT   = CLK_FREQ / BAUD;
    localparam int HALF  = BIT / 2;
    localparam int CNT_W = $clog2(BIT + 1);

    localparam logic [CNT_W-1:0] HALF_C = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] BIT_C  = CNT_W'(BIT);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_rx_d;
    logic [1:0]       r_arm;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_frame_err;
    logic             r_overrun;

    logic             w_fall;
    logic             w_half_hit;
    logic             w_bit_hit;
    logic             w_push;
    logic             w_ferr_set;
    logic             w_pop;
    logic             w_accept;
    logic             w_full;
    logic             w_valid;

    // Input synchronizer and one-cycle-delayed copy for falling-edge detection.
    // r_rx_d is held at 0 until the synchronizer has flushed its reset value,
    // so a line that is already low at reset release never looks like a start.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, giving a true shift chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_rx_d  <= 1'b0;
            r_arm   <= 2'b00;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_arm   <= {r_arm[0], 1'b1};
            r_rx_d  <= r_arm[1] & r_sync2;
        end
    end

    assign w_fall     = r_rx_d & ~r_sync2;
    assign w_half_hit = (r_cnt == HALF_C);
    assign w_bit_hit  = (r_cnt == BIT_C);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; unused encodings fall back to IDLE.
    // NOTE: the default assignment at the top keeps this block free of latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:      if (w_fall) w_next_state = START;
            START:     if (w_half_hit) w_next_state = r_sync2 ? IDLE : DATA;
            DATA:      if (w_bit_hit && (r_bit_idx == 3'd7)) w_next_state = STOP;
            STOP:      if (w_bit_hit) w_next_state = r_sync2 ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (r_sync2) w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    // Output decode: stop-bit sample produces either a push or a framing error.
    always_comb begin
        w_push     = 1'b0;
        w_ferr_set = 1'b0;
        case (r_state)
            STOP: begin
                if (w_bit_hit) begin
                    w_push     = r_sync2;
                    w_ferr_set = ~r_sync2;
                end
            end
            default: ;
        endcase
    end

    // Bit-timing counter, bit index and LSB-first shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt     <= w_fall ? ONE_C : '0;
                    r_bit_idx <= '0;
                end
                START: begin
                    r_cnt <= w_half_hit ? ONE_C : r_cnt + 1'b1;
                end
                DATA: begin
                    if (w_bit_hit) begin
                        r_cnt     <= ONE_C;
                        r_shift   <= {r_sync2, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    r_cnt <= w_bit_hit ? '0 : r_cnt + 1'b1;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign w_pop    = w_valid & rx_ready;
    assign w_accept = w_push & (~w_full | w_pop);

    // One-cycle error pulses, registered one cycle after the stop-bit sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr_set;
            r_overrun   <= w_push & w_full & ~w_pop;
        end
    end

`ifdef UART_RX_FIFO_EN
    logic [7:0] r_mem [4];
    logic [1:0] r_wr_ptr;
    logic [1:0] r_rd_ptr;
    logic [2:0] r_count;

    assign w_full  = (r_count == 3'd4);
    assign w_valid = (r_count != 3'd0);

    // FIFO storage write port.
    // NOTE: the array has no reset; the pointers and count define what is
    // valid, and rx_data is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally modulo 4.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rx_data = w_valid ? r_mem[r_rd_ptr] : 8'h00;
`else
    logic [7:0] r_hold;
    logic       r_valid;

    assign w_full  = r_valid;
    assign w_valid = r_valid;

    // Single holding register; a push on the pop cycle replaces the old byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold  <= 8'h00;
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_hold  <= r_shift;
            r_valid <= 1'b1;
        end else if (w_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign rx_data = r_hold;
`endif

    assign rx_valid  = w_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
